// File: rtl/mm_pkg.sv
// mm_pkg: shared types and default timing for the PE sequencer
package mm_pkg;
  typedef logic [31:0] float32_t;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, MULT, ADD, OUT, WAIT, RESP} seq_state_t;
  localparam int MULT_CYC_D = 5;
  localparam int ADD_CYC_D = 7;
  localparam int OUT_LAT_D = 1;
  localparam int KW_D = 4;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/pe_sequencer.sv
// pe_sequencer: sequences a K-term dot product through the PE (clear, fetch, mult, add, out) and returns Cout via valid/ready
//   clk, reset(active-low sync) | start, k_len: job request | op_valid/op_ready, op_a, op_b: operand stream
//   pe_reset, pe_mult_en, pe_add_en, pe_out_en, pe_ain, pe_bin -> PE | pe_cout, pe_overflow <- PE
//   res_valid/res_ready, res_data, res_ovf: result | busy: not IDLE
module pe_sequencer
  import mm_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_D,
  parameter int ADD_CYC = ADD_CYC_D,
  parameter int OUT_LAT = OUT_LAT_D,
  parameter int KW = KW_D
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          op_valid,
  output logic          op_ready,
  input  float32_t      op_a,
  input  float32_t      op_b,
  output logic          pe_reset,
  output logic          pe_mult_en,
  output logic          pe_add_en,
  output logic          pe_out_en,
  output float32_t      pe_ain,
  output float32_t      pe_bin,
  input  float32_t      pe_cout,
  input  logic          pe_overflow,
  output logic          res_valid,
  input  logic          res_ready,
  output float32_t      res_data,
  output logic          res_ovf,
  output logic          busy
);
  localparam int CW = $clog2(max3(MULT_CYC, ADD_CYC, OUT_LAT) + 1);
  seq_state_t state, state_n;
  logic [CW-1:0] cnt, lim;
  logic [KW-1:0] terms;
  logic sticky, done, accept;
  always_comb begin
    lim = state == MULT ? CW'(MULT_CYC - 1) : state == ADD ? CW'(ADD_CYC - 1) : CW'(OUT_LAT - 1);
    done = cnt == lim;
    // op_ready is registered, so it is only ever high while in FETCH
    accept = op_valid & op_ready;
    busy = state != IDLE;
    state_n = state;
    case (state)
      IDLE:  state_n = start && k_len != '0 ? CLEAR : IDLE;
      CLEAR: state_n = FETCH;
      FETCH: state_n = accept ? MULT : FETCH;
      MULT:  state_n = done ? ADD : MULT;
      ADD:   state_n = done ? (terms == KW'(1) ? OUT : FETCH) : ADD;
      OUT:   state_n = WAIT;
      WAIT:  state_n = done ? RESP : WAIT;
      RESP:  state_n = res_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      terms <= '0;
      sticky <= 1'b0;
      op_ready <= 1'b0;
      pe_reset <= 1'b1;
      pe_mult_en <= 1'b0;
      pe_add_en <= 1'b0;
      pe_out_en <= 1'b0;
      pe_ain <= '0;
      pe_bin <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_ovf <= 1'b0;
    end else begin
      state <= state_n;
      // phase counter restarts on every state change; wrap while idling/stalling is harmless
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      if (state == IDLE && state_n == CLEAR) terms <= k_len;
      else if (state == ADD && done) terms <= terms - 1'b1;
      sticky <= state == CLEAR ? 1'b0 : sticky | (state == ADD && pe_overflow);
      // ready rises one cycle after entering FETCH, giving a flopped handshake output
      op_ready <= state == FETCH && !accept;
      if (accept) begin
        pe_ain <= op_a;
        pe_bin <= op_b;
      end
      pe_reset <= state_n == CLEAR;
      pe_mult_en <= state_n == MULT;
      pe_add_en <= state_n == ADD;
      pe_out_en <= state_n == OUT;
      res_valid <= state_n == RESP;
      if (state == WAIT && done) begin
        res_data <= pe_cout;
        res_ovf <= sticky;
      end
    end
  end
endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: directed scoreboard bench for pe_sequencer with a behavioural PE model
module tb_pe_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, op_valid = 1'b0, res_ready = 1'b1;
  logic [3:0] k_len = '0;
  logic [31:0] op_a = '0, op_b = '0, pe_ain, pe_bin, pe_cout, res_data;
  logic op_ready, pe_reset, pe_mult_en, pe_add_en, pe_out_en, pe_overflow, res_valid, res_ovf, busy;
  int total = 0, fails = 0;
  typedef struct {logic [31:0] data; logic ovf; int lat; bit cd;} exp_t;
  exp_t sb[$];

  always #20 clk = ~clk;

  pe_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .pe_reset(pe_reset), .pe_mult_en(pe_mult_en), .pe_add_en(pe_add_en),
    .pe_out_en(pe_out_en), .pe_ain(pe_ain), .pe_bin(pe_bin), .pe_cout(pe_cout), .pe_overflow(pe_overflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
  );

  function automatic real f2r(input logic [31:0] f);
    int e;
    real m;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    for (int i = 127; i < e; i++) m = m * 2.0;
    for (int i = e; i < 127; i++) m = m / 2.0;
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic s;
    int e;
    real a;
    longint mi;
    logic [31:0] r;
    if (v == 0.0) return 32'h0;
    s = v < 0.0;
    a = s ? -v : v;
    e = 127;
    while (a >= 2.0 && e < 400) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > -400) begin a = a * 2.0; e--; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    mi = longint'((a - 1.0) * 8388608.0);
    if (mi == 64'sd8388608) begin mi = 0; e++; end
    r = {s, e[7:0], mi[22:0]};
    return r;
  endfunction

  // PE stand-in: product captured on mult_en rise, accumulated on add_en rise, Cout one cycle after out_en
  real acc = 0.0, prod = 0.0;
  logic mult_d = 1'b0, add_d = 1'b0, out_d = 1'b0;
  logic [31:0] cout_r = '0;
  assign pe_cout = cout_r;
  always_comb pe_overflow = pe_add_en && (acc >= 3.402823669209385e38 || acc <= -3.402823669209385e38);
  always @(posedge clk) begin
    mult_d <= pe_mult_en;
    add_d <= pe_add_en;
    out_d <= pe_out_en;
    if (pe_mult_en && !mult_d) prod <= f2r(pe_ain) * f2r(pe_bin);
    if (pe_reset) acc <= 0.0;
    else if (pe_add_en && !add_d) acc <= acc + prod;
    if (pe_out_en && !out_d) cout_r <= r2f(acc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    logic [31:0] d;
    d = obs > expv ? obs - expv : expv - obs;
    total++;
    assert (d <= 32'd1) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h +/-1ulp", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_job(input logic [3:0] k, input logic [31:0] a, input logic [31:0] b, input int fstall,
                        input int rhold, input bit poke, input logic [31:0] ed, input logic eo, input int el,
                        input bit cd);
    exp_t e;
    int n, cm, ca, co;
    logic [31:0] held;
    e.data = ed; e.ovf = eo; e.lat = el; e.cd = cd;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; k_len = k; op_a = a; op_b = b; op_valid = fstall == 0; res_ready = rhold == 0;
    n = 0; cm = 0; ca = 0; co = 0;
    while (n < 400) begin
      cyc();
      n++;
      start = poke && n == 6;
      k_len = poke && n == 6 ? 4'd3 : k;
      if (fstall > 0 && n == 3 + fstall) op_valid = 1'b1;
      if (!op_valid && n >= 3) chk("stall_en", {29'h0, pe_mult_en, pe_add_en, pe_out_en}, 32'h0);
      chk("excl_en", 32'($countones({pe_mult_en, pe_add_en, pe_out_en}) <= 1), 32'h1);
      cm += int'(pe_mult_en); ca += int'(pe_add_en); co += int'(pe_out_en);
      if (res_valid) break;
    end
    e = sb.pop_front();
    chk("latency", 32'(n), 32'(e.lat));
    if (e.cd) chk_ulp("res_data", res_data, e.data);
    chk("res_ovf", {31'h0, res_ovf}, {31'h0, e.ovf});
    chk("mult_cycles", 32'(cm), 32'(5 * int'(k)));
    chk("add_cycles", 32'(ca), 32'(7 * int'(k)));
    chk("out_cycles", 32'(co), 32'h1);
    held = res_data;
    for (int i = 0; i < rhold; i++) begin
      cyc();
      chk("hold_valid", {31'h0, res_valid}, 32'h1);
      chk("hold_data", res_data, held);
    end
    res_ready = 1'b1;
    cyc();
    chk("done_valid", {31'h0, res_valid}, 32'h0);
    chk("done_busy", {31'h0, busy}, 32'h0);
    op_valid = 1'b0;
  endtask

  initial begin
    int n, rv;
    cyc();
    cyc();
    chk("rst_pe_reset", {31'h0, pe_reset}, 32'h1);
    chk("rst_en", {29'h0, pe_mult_en, pe_add_en, pe_out_en}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_op_ready", {31'h0, op_ready}, 32'h0);
    @(negedge clk) reset = 1'b1;
    cyc();
    do_job(4'd1, 32'h400CCCCD, 32'h40533333, 0, 0, 1'b0, 32'h40E851EC, 1'b0, 18, 1'b1);
    do_job(4'd2, 32'h400CCCCD, 32'h40533333, 0, 0, 1'b0, 32'h416851EC, 1'b0, 32, 1'b1);
    do_job(4'd1, 32'h400CCCCD, 32'h40533333, 10, 5, 1'b0, 32'h40E851EC, 1'b0, 28, 1'b1);
    @(negedge clk);
    start = 1'b1; k_len = 4'd2; op_a = 32'h400CCCCD; op_b = 32'h40533333; op_valid = 1'b1;
    n = 0;
    while (!pe_add_en && n < 50) begin
      cyc();
      n++;
      start = 1'b0;
    end
    chk("reach_add", {31'h0, pe_add_en}, 32'h1);
    reset = 1'b0;
    cyc();
    chk("mid_rst_pe_reset", {31'h0, pe_reset}, 32'h1);
    chk("mid_rst_en", {29'h0, pe_mult_en, pe_add_en, pe_out_en}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_op_ready", {31'h0, op_ready}, 32'h0);
    chk("mid_rst_res", {30'h0, res_valid, res_ovf}, 32'h0);
    chk("mid_rst_data", res_data, 32'h0);
    reset = 1'b1;
    op_valid = 1'b0;
    rv = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      rv += int'(res_valid);
    end
    chk("abandoned_no_res", 32'(rv), 32'h0);
    do_job(4'd1, 32'h400CCCCD, 32'h40533333, 0, 0, 1'b0, 32'h40E851EC, 1'b0, 18, 1'b1);
    do_job(4'd1, 32'h7F000000, 32'h7F000000, 0, 0, 1'b1, 32'h0, 1'b1, 18, 1'b0);
    @(negedge clk);
    start = 1'b1; k_len = 4'd0;
    cyc();
    start = 1'b0;
    chk("k0_busy", {31'h0, busy}, 32'h0);
    cyc();
    chk("k0_busy2", {30'h0, busy, pe_reset}, 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
